rtp_result_monitor: RTL and testbench

- Synthesizable multi-channel result collector and performance monitor for NUM_CH ray-tracing pipelines.
- Arbitrates per-channel hit results (hitT, ray id) round-robin into a shared FIFO with valid/ready output.
- Counts run cycles and accepted results, detects all-channel finish and stalls via a watchdog.
- Replaces bench-only cycle counting and single-channel finish monitoring at the top level.

---
 rtl/rtp_result_monitor.sv | 144 ++++++++++++++
 tb/tb_rtp_result_monitor.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/rtp_result_monitor.sv
// Multi-channel result collector: round-robin arbitration of per-channel hits into a FWFT FIFO,
// plus run-cycle/result counters, all-channel finish detection and an idle watchdog.
module rtp_result_monitor #(
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned CNT_W      = 64,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned TIMEOUT    = 1000000,
  localparam int unsigned CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic [NUM_CH-1:0]        ch_valid,
  input  logic [NUM_CH*DATA_W-1:0] ch_hitT,
  input  logic [NUM_CH*DATA_W-1:0] ch_ray_id,
  input  logic [NUM_CH-1:0]        ch_finish,
  output logic [NUM_CH-1:0]        ch_ready,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [DATA_W-1:0]        res_hitT,
  output logic [DATA_W-1:0]        res_ray_id,
  output logic [CH_W-1:0]          res_ch,
  output logic [CNT_W-1:0]         total_cycle,
  output logic [CNT_W-1:0]         result_count,
  output logic                     run_done,
  output logic                     timeout,
  output logic [1:0]               state
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {StIdle = 2'd0, StRun = 2'd1, StDone = 2'd2, StTimeout = 2'd3} state_e;

  state_e              r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_tc, r_rc;
  logic [NUM_CH-1:0]   r_fin, w_fin_all;
  logic [CH_W-1:0]     r_ptr, w_grant_idx, w_idx;
  logic [31:0]         r_idle;
  logic [NUM_CH-1:0]   w_grant;
  logic                w_accept, w_full, w_empty, w_pop;
  logic [AW-1:0]       r_wr, r_rd;
  logic [CW-1:0]       r_cnt;
  logic [DATA_W-1:0]   r_mem_hit [FIFO_DEPTH];
  logic [DATA_W-1:0]   r_mem_id  [FIFO_DEPTH];
  logic [CH_W-1:0]     r_mem_ch  [FIFO_DEPTH];

  assign w_full    = (r_cnt == CW'(FIFO_DEPTH));
  assign w_empty   = (r_cnt == '0);
  assign w_pop     = !w_empty && res_ready;
  assign w_fin_all = r_fin | ch_finish;

  // First valid channel at or after the RR pointer; nothing granted on a start cycle.
  always_comb begin
    w_grant     = '0;
    w_grant_idx = '0;
    w_accept    = 1'b0;
    w_idx       = '0;
    if (r_state == StRun && !start && !w_full) begin
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        w_idx = CH_W'((32'(r_ptr) + k) % NUM_CH);
        if (!w_accept && ch_valid[w_idx]) begin
          w_accept       = 1'b1;
          w_grant[w_idx] = 1'b1;
          w_grant_idx    = w_idx;
        end
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == StRun && !w_accept) begin
      if (&w_fin_all) begin
        w_state_nxt = StDone;
      end else if (TIMEOUT != 0 && r_idle == 32'(TIMEOUT - 1)) begin
        w_state_nxt = StTimeout;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= StIdle;
      r_tc    <= '0;
      r_rc    <= '0;
      r_fin   <= '0;
      r_ptr   <= '0;
      r_idle  <= '0;
      r_wr    <= '0;
      r_rd    <= '0;
      r_cnt   <= '0;
    end else if (start) begin
      r_state <= StRun;
      r_tc    <= '0;
      r_rc    <= '0;
      r_fin   <= '0;
      r_ptr   <= '0;
      r_idle  <= '0;
      r_wr    <= '0;
      r_rd    <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) r_wr <= r_wr + AW'(1);
      if (w_pop)    r_rd <= r_rd + AW'(1);
      if (w_accept && !w_pop)      r_cnt <= r_cnt + CW'(1);
      else if (!w_accept && w_pop) r_cnt <= r_cnt - CW'(1);
      if (r_state == StRun) begin
        r_tc  <= (&r_tc) ? r_tc : r_tc + CNT_W'(1);
        r_fin <= w_fin_all;
        if (w_accept) begin
          r_ptr  <= CH_W'((32'(w_grant_idx) + 1) % NUM_CH);
          r_rc   <= (&r_rc) ? r_rc : r_rc + CNT_W'(1);
          r_idle <= '0;
        end else begin
          r_idle <= (&r_idle) ? r_idle : r_idle + 32'd1;
        end
      end
    end
  end

  // Storage needs no reset: the head is masked whenever the FIFO is empty.
  always_ff @(posedge clock) begin
    if (w_accept) begin
      r_mem_hit[r_wr] <= ch_hitT[w_grant_idx*DATA_W +: DATA_W];
      r_mem_id[r_wr]  <= ch_ray_id[w_grant_idx*DATA_W +: DATA_W];
      r_mem_ch[r_wr]  <= w_grant_idx;
    end
  end

  assign ch_ready     = w_grant;
  assign res_valid    = !w_empty;
  assign res_hitT     = w_empty ? '0 : r_mem_hit[r_rd];
  assign res_ray_id   = w_empty ? '0 : r_mem_id[r_rd];
  assign res_ch       = w_empty ? '0 : r_mem_ch[r_rd];
  assign total_cycle  = r_tc;
  assign result_count = r_rc;
  assign run_done     = (r_state == StDone);
  assign timeout      = (r_state == StTimeout);
  assign state        = r_state;

endmodule

// File: tb/tb_rtp_result_monitor.sv
// Scoreboard bench for rtp_result_monitor: a per-cycle reference model predicts grants/state,
// accepted results are queued and checked by an independent output monitor.
module tb_rtp_result_monitor;

  localparam int unsigned NCH = 2;
  localparam int unsigned DW  = 32;
  localparam int unsigned TO  = 20;
  localparam int unsigned DEP = 8;

  logic            clock, reset, start, res_valid, res_ready, run_done, timeout;
  logic [NCH-1:0]  ch_valid, ch_finish, ch_ready;
  logic [NCH*DW-1:0] ch_hitT, ch_ray_id;
  logic [DW-1:0]   res_hitT, res_ray_id;
  logic [0:0]      res_ch;
  logic [63:0]     total_cycle, result_count;
  logic [1:0]      state;

  rtp_result_monitor #(
    .NUM_CH(NCH), .DATA_W(DW), .CNT_W(64), .FIFO_DEPTH(DEP), .TIMEOUT(TO)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .ch_valid(ch_valid), .ch_hitT(ch_hitT),
    .ch_ray_id(ch_ray_id), .ch_finish(ch_finish), .ch_ready(ch_ready), .res_valid(res_valid),
    .res_ready(res_ready), .res_hitT(res_hitT), .res_ray_id(res_ray_id), .res_ch(res_ch),
    .total_cycle(total_cycle), .result_count(result_count), .run_done(run_done),
    .timeout(timeout), .state(state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [DW-1:0] hit;
    logic [DW-1:0] id;
    logic [0:0]    ch;
  } ent_t;

  ent_t sbq[$];
  int checks = 0;
  int failures = 0;

  // Reference model state: 0 idle, 1 run, 2 done, 3 timeout
  int m_state, m_ptr, m_cnt, m_idle;
  longint unsigned m_tc, m_rc;
  bit [NCH-1:0] m_fin;
  int unsigned rid;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic model_reset();
    m_state = 0; m_ptr = 0; m_cnt = 0; m_idle = 0; m_tc = 0; m_rc = 0; m_fin = '0;
  endtask

  // Output monitor: every pop of the DUT FIFO must match the oldest predicted entry.
  always @(negedge clock) begin
    if (reset && res_valid && res_ready) begin
      if (sbq.size() == 0) begin
        chk("pop_with_empty_scoreboard", 64'd1, 64'd0);
      end else begin
        ent_t e;
        e = sbq.pop_front();
        chk("res_hitT", 64'(res_hitT), 64'(e.hit));
        chk("res_ray_id", 64'(res_ray_id), 64'(e.id));
        chk("res_ch", 64'(res_ch), 64'(e.ch));
      end
    end
  end

  task automatic step(input bit st, input logic [NCH-1:0] v, input logic [NCH-1:0] f,
                      input bit rr);
    int g;
    bit pop, do_push;
    ent_t e;
    logic [NCH-1:0] exp_rdy;
    start = st; ch_valid = v; ch_finish = f; res_ready = rr;
    ch_hitT = {$urandom, $urandom};
    ch_ray_id = {rid + 32'd1, rid};
    rid += 2;
    @(negedge clock);
    g = -1;
    if (m_state == 1 && !st && m_cnt < DEP) begin
      for (int k = 0; k < NCH; k++) begin
        int idx;
        idx = (m_ptr + k) % NCH;
        if (g < 0 && v[idx]) g = idx;
      end
    end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("ch_ready", 64'(ch_ready), 64'(exp_rdy));
    chk("res_valid", 64'(res_valid), 64'(m_cnt > 0));
    chk("state", 64'(state), 64'(m_state));
    chk("total_cycle", total_cycle, m_tc);
    chk("result_count", result_count, m_rc);
    chk("run_done", 64'(run_done), 64'(m_state == 2));
    chk("timeout", 64'(timeout), 64'(m_state == 3));
    pop = (m_cnt > 0) && rr;
    do_push = 1'b0;
    if (st) begin
      model_reset();
      m_state = 1;
    end else begin
      if (m_state == 1) begin
        bit [NCH-1:0] fin_now;
        bit go_done, go_to;
        fin_now = m_fin | f;
        go_done = (fin_now == '1) && (g < 0);
        go_to   = (g < 0) && (m_idle == TO - 1);
        m_tc++;
        m_fin = fin_now;
        if (g >= 0) begin
          do_push = 1'b1;
          e.hit = ch_hitT[g*DW +: DW];
          e.id  = ch_ray_id[g*DW +: DW];
          e.ch  = 1'(g);
          m_ptr = (g + 1) % NCH;
          m_rc++;
          m_idle = 0;
        end else begin
          m_idle++;
        end
        if (go_done) m_state = 2;
        else if (go_to) m_state = 3;
      end
      m_cnt = m_cnt + int'(do_push) - int'(pop);
    end
    @(posedge clock);
    if (st) sbq.delete();
    if (do_push) sbq.push_back(e);
    #1;
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; ch_valid = '0; ch_finish = '0; res_ready = 1'b0;
    ch_hitT = '0; ch_ray_id = '0; rid = 0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    chk("rst_state", 64'(state), 64'd0);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_total_cycle", total_cycle, 64'd0);
    chk("rst_ch_ready", 64'(ch_ready), 64'd0);
    chk("rst_res_hitT", 64'(res_hitT), 64'd0);
    reset = 1'b1;

    // Both channels always valid: grants alternate
    step(1, '0, '0, 0);
    for (int i = 0; i < 10; i++) step(0, 2'b11, '0, 1);
    chk("rc_after_10", result_count, 64'd10);
    repeat (3) step(0, '0, '0, 1);

    // Fill to full with no consumer, then one pop frees exactly one slot
    step(1, '0, '0, 0);
    for (int i = 0; i < 12; i++) step(0, 2'b01, '0, 0);
    chk("rc_full", result_count, 64'd8);
    step(0, 2'b01, '0, 1);
    step(0, 2'b01, '0, 0);
    chk("rc_after_pop", result_count, 64'd9);
    repeat (10) step(0, '0, '0, 1);

    // Result and finish arrive together: accepted, DONE a cycle later
    step(1, '0, '0, 0);
    step(0, 2'b01, 2'b11, 0);
    step(0, '0, '0, 0);
    chk("done_state", 64'(state), 64'd2);
    chk("done_tc", total_cycle, 64'd2);
    repeat (3) step(0, '0, '0, 1);
    chk("done_tc_frozen", total_cycle, 64'd2);

    // Watchdog
    step(1, '0, '0, 1);
    for (int i = 0; i < 25; i++) step(0, '0, '0, 1);
    chk("to_state", 64'(state), 64'd3);
    chk("to_tc", total_cycle, 64'd20);
    step(1, '0, '0, 0);
    chk("restart_state", 64'(state), 64'd1);
    chk("restart_tc", total_cycle, 64'd0);

    // Start flushes a non-empty FIFO
    step(0, 2'b01, '0, 0);
    step(0, 2'b01, '0, 0);
    step(1, '0, '0, 0);
    chk("flush_res_valid", 64'(res_valid), 64'd0);
    chk("flush_rc", result_count, 64'd0);
    chk("flush_state", 64'(state), 64'd1);

    // Asynchronous reset mid-run with three entries queued
    repeat (3) step(0, 2'b11, '0, 0);
    #1 reset = 1'b0;
    #1;
    chk("arst_state", 64'(state), 64'd0);
    chk("arst_res_valid", 64'(res_valid), 64'd0);
    chk("arst_tc", total_cycle, 64'd0);
    reset = 1'b1;
    model_reset();
    sbq.delete();

    // Randomized traffic
    step(1, '0, '0, 1);
    for (int i = 0; i < 600; i++) begin
      logic [NCH-1:0] v, f;
      v = NCH'($urandom);
      f = ($urandom_range(0, 29) == 0) ? NCH'($urandom) : '0;
      step($urandom_range(0, 99) == 0, v, f, $urandom_range(0, 3) != 0);
    end
    repeat (10) step(0, '0, '0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
